// File: rtl/ram_program_loader_pkg.sv
// Shared definitions for the RAM program loader: sequencer states, error codes
// and the default RAM bus widths (adlines/datalines).
package ram_program_loader_pkg;

    localparam int ADLINES   = 8;
    localparam int DATALINES = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_GAP,
        S_VREAD,
        S_CHECK,
        S_DONE,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_VERIFY   = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;

endpackage

// File: rtl/ram_program_loader_if.sv
// Word-stream handshake plus RAM address/data/strobe lines between the loader
// (slave) and the host stream / RAMblock side (master).
interface ram_program_loader_if
    import ram_program_loader_pkg::*;
#(
    parameter int ADDR_W = ADLINES,
    parameter int DATA_W = DATALINES
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic [ADDR_W-1:0] addressbus;
    logic [DATA_W-1:0] toram;
    logic [DATA_W-1:0] fromram;
    logic              read;
    logic              write;

    modport master (
        output in_valid, in_data, in_last, fromram,
        input  in_ready, addressbus, toram, read, write
    );

    modport slave (
        input  in_valid, in_data, in_last, fromram,
        output in_ready, addressbus, toram, read, write
    );
endinterface

// File: rtl/ram_program_loader_strobe_timer.sv
// Load/count-down timer with a zero flag; times how long a RAM strobe is held.
module strobe_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/ram_program_loader.sv
// Self-timed sequencer that streams a program image into RAM, optionally reads
// each word back to verify it, then enables the control unit.
module ram_program_loader
    import ram_program_loader_pkg::*;
#(
    parameter int ADDR_W       = ADLINES,
    parameter int DATA_W       = DATALINES,
    parameter int BASE_ADDR    = 0,
    parameter int MAX_WORDS    = 256,
    parameter int WRITE_CYCLES = 2,
    parameter int READ_CYCLES  = 2,
    parameter int VERIFY       = 1,
    parameter int AUTO_RUN     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  halt,
    ram_program_loader_if.slave   bus,
    output logic                  cu_enable,
    output logic                  busy,
    output logic [1:0]            err_code,
    output logic [ADDR_W:0]       word_count
);
    localparam int               CNT_W   = 16;
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_CYCLES - 1);
    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] toram_q;
    logic              last_q;
    logic              read_q;
    logic              write_q;
    logic              in_ready_q;
    logic [ADDR_W:0]   count_nxt;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_zero;

    // The timer is armed on the same edge that enters WRITE or VREAD, so the
    // strobe stays high for exactly the configured number of cycles.
    assign tmr_load  = ((state == S_ACCEPT) && bus.in_valid) ||
                       ((state == S_GAP) && (VERIFY != 0));
    assign tmr_val   = (state == S_ACCEPT) ? WR_LOAD : RD_LOAD;
    assign count_nxt = word_count + 1'b1;

    strobe_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            addr       <= '0;
            toram_q    <= '0;
            last_q     <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            in_ready_q <= 1'b0;
            cu_enable  <= 1'b0;
            busy       <= 1'b0;
            err_code   <= ERR_NONE;
            word_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (load_start) begin
                        state      <= S_ACCEPT;
                        addr       <= BASE;
                        word_count <= '0;
                        err_code   <= ERR_NONE;
                        in_ready_q <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_ACCEPT: begin
                    if (bus.in_valid) begin
                        toram_q    <= bus.in_data;
                        last_q     <= bus.in_last;
                        in_ready_q <= 1'b0;
                        write_q    <= 1'b1;
                        state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (tmr_zero) begin
                        write_q <= 1'b0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (VERIFY != 0) begin
                        read_q <= 1'b1;
                        state  <= S_VREAD;
                    end else begin
                        state <= S_CHECK;
                    end
                end
                S_VREAD: begin
                    if (tmr_zero) begin
                        read_q <= 1'b0;
                        if (bus.fromram != toram_q) begin
                            state    <= S_ERROR;
                            err_code <= ERR_VERIFY;
                            busy     <= 1'b0;
                        end else begin
                            state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    word_count <= count_nxt;
                    if (last_q) begin
                        busy <= 1'b0;
                        if (AUTO_RUN != 0) begin
                            state     <= S_RUN;
                            cu_enable <= 1'b1;
                        end else begin
                            state <= S_DONE;
                        end
                    end else if (count_nxt == MAX_CNT) begin
                        state    <= S_ERROR;
                        err_code <= ERR_OVERFLOW;
                        busy     <= 1'b0;
                    end else begin
                        // Address wraps naturally at 2**ADDR_W.
                        addr       <= addr + 1'b1;
                        in_ready_q <= 1'b1;
                        state      <= S_ACCEPT;
                    end
                end
                S_RUN: begin
                    if (halt) begin
                        cu_enable <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.addressbus = addr;
    assign bus.toram      = toram_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
endmodule

// File: tb/tb_ram_program_loader.sv
// Directed bench for ram_program_loader: two configurations, each with a small
// behavioural RAM, checked against hand-computed expectations.
module tb_ram_program_loader;
    import ram_program_loader_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       load_start_a;
    logic       load_start_b;
    logic       halt;
    logic       cu_enable_a, busy_a, cu_enable_b, busy_b;
    logic [1:0] err_a, err_b;
    logic [8:0] wc_a, wc_b;
    logic       fault_a;

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int wr_cnt_a = 0;
    int rd_cnt_a = 0;
    int both_hi = 0;
    int acc_cyc = 0;

    ram_program_loader_if #(.ADDR_W(8), .DATA_W(16)) ifa ();
    ram_program_loader_if #(.ADDR_W(8), .DATA_W(16)) ifb ();

    ram_program_loader #(
        .ADDR_W(8), .DATA_W(16), .BASE_ADDR(0), .MAX_WORDS(256),
        .WRITE_CYCLES(3), .READ_CYCLES(3), .VERIFY(1), .AUTO_RUN(1)
    ) dut_a (
        .clk(clk), .reset(reset), .load_start(load_start_a), .halt(halt),
        .bus(ifa), .cu_enable(cu_enable_a), .busy(busy_a),
        .err_code(err_a), .word_count(wc_a)
    );

    ram_program_loader #(
        .ADDR_W(8), .DATA_W(16), .BASE_ADDR(8'hFE), .MAX_WORDS(4),
        .WRITE_CYCLES(2), .READ_CYCLES(2), .VERIFY(0), .AUTO_RUN(0)
    ) dut_b (
        .clk(clk), .reset(reset), .load_start(load_start_b), .halt(halt),
        .bus(ifb), .cu_enable(cu_enable_b), .busy(busy_b),
        .err_code(err_b), .word_count(wc_b)
    );

    // RAM models; fault_a flips bit 3 of the word read back from address 2.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifa.write) begin
            mem_a[ifa.addressbus] <= ifa.toram;
            wr_cnt_a <= wr_cnt_a + 1;
        end
        if (ifa.read) rd_cnt_a <= rd_cnt_a + 1;
        if (ifb.write) mem_b[ifb.addressbus] <= ifb.toram;
        if ((ifa.read && ifa.write) || (ifb.read && ifb.write)) both_hi <= both_hi + 1;
    end

    assign ifa.fromram = mem_a[ifa.addressbus] ^
                         ((fault_a && ifa.addressbus == 8'd2) ? 16'h0008 : 16'h0000);
    assign ifb.fromram = mem_b[ifb.addressbus];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_a(input logic [15:0] d, input logic l, input int gap);
        repeat (gap) @(negedge clk);
        ifa.in_valid = 1'b1;
        ifa.in_data  = d;
        ifa.in_last  = l;
        for (int n = 0; n < 40 && !ifa.in_ready; n++) @(negedge clk);
        check("a_ready_seen", {31'd0, ifa.in_ready}, 32'd1);
        @(negedge clk);
        acc_cyc = cyc;
        ifa.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] d, input logic l);
        ifb.in_valid = 1'b1;
        ifb.in_data  = d;
        ifb.in_last  = l;
        for (int n = 0; n < 40 && !ifb.in_ready; n++) @(negedge clk);
        check("b_ready_seen", {31'd0, ifb.in_ready}, 32'd1);
        @(negedge clk);
        ifb.in_valid = 1'b0;
    endtask

    task automatic pulse_a();
        load_start_a = 1'b1;
        @(negedge clk);
        load_start_a = 1'b0;
    endtask

    task automatic pulse_b();
        load_start_b = 1'b1;
        @(negedge clk);
        load_start_b = 1'b0;
    endtask

    task automatic wait_run_a(input string tag);
        for (int n = 0; n < 40 && !cu_enable_a; n++) @(negedge clk);
        check(tag, {31'd0, cu_enable_a}, 32'd1);
    endtask

    task automatic wait_idle_a(input string tag);
        for (int n = 0; n < 40 && busy_a; n++) @(negedge clk);
        check(tag, {31'd0, busy_a}, 32'd0);
    endtask

    task automatic wait_idle_b(input string tag);
        for (int n = 0; n < 40 && busy_b; n++) @(negedge clk);
        check(tag, {31'd0, busy_b}, 32'd0);
    endtask

    task automatic halt_pulse();
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int ready_seen;
        logic [15:0] img1 [5];
        img1[0] = 16'h0086; img1[1] = 16'h018E; img1[2] = 16'h0000;
        img1[3] = 16'h0005; img1[4] = 16'h0002;

        reset = 1'b1; load_start_a = 1'b0; load_start_b = 1'b0; halt = 1'b0; fault_a = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_last = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_last = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_a_ctrl", {26'd0, ifa.in_ready, ifa.read, ifa.write, cu_enable_a, busy_a, err_a}, 32'd0);
        check("rst_a_addr", {24'd0, ifa.addressbus}, 32'd0);
        check("rst_a_data", {16'd0, ifa.toram}, 32'd0);
        check("rst_a_count", {23'd0, wc_a}, 32'd0);
        check("rst_b_ctrl", {26'd0, ifb.in_ready, ifb.read, ifb.write, cu_enable_b, busy_b, err_b}, 32'd0);
        check("rst_b_addr", {24'd0, ifb.addressbus}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Test 1: five-word image, verify on, auto-run
        pulse_a();
        check("t1_busy", {31'd0, busy_a}, 32'd1);
        check("t1_in_ready", {31'd0, ifa.in_ready}, 32'd1);
        send_a(img1[0], 1'b0, 0);
        t0 = acc_cyc;
        send_a(img1[1], 1'b0, 0);
        check("t1_cycles_per_word", acc_cyc - t0, 32'd9);
        send_a(img1[2], 1'b0, 0);
        send_a(img1[3], 1'b0, 0);
        send_a(img1[4], 1'b1, 0);
        wait_run_a("t1_cu_enable");
        for (int i = 0; i < 5; i++) check($sformatf("t1_ram%0d", i), {16'd0, mem_a[i]}, {16'd0, img1[i]});
        check("t1_word_count", {23'd0, wc_a}, 32'd5);
        check("t1_err", {30'd0, err_a}, 32'd0);
        check("t1_busy_low", {31'd0, busy_a}, 32'd0);
        check("t1_write_cycles", wr_cnt_a, 32'd15);
        check("t1_read_cycles", rd_cnt_a, 32'd15);

        // Test 6: halt from RUN, then a load with 3-cycle valid gaps
        halt_pulse();
        check("t6_halt_cu", {31'd0, cu_enable_a}, 32'd0);
        check("t6_halt_idle", {30'd0, busy_a, ifa.in_ready}, 32'd0);
        pulse_a();
        send_a(16'hA001, 1'b0, 3);
        send_a(16'hA002, 1'b0, 3);
        send_a(16'hA003, 1'b1, 3);
        wait_run_a("t6_cu_enable");
        check("t6_ram0", {16'd0, mem_a[0]}, 32'hA001);
        check("t6_ram1", {16'd0, mem_a[1]}, 32'hA002);
        check("t6_ram2", {16'd0, mem_a[2]}, 32'hA003);
        check("t6_word_count", {23'd0, wc_a}, 32'd3);
        halt_pulse();

        // Test 2: corrupted read-back at address 2
        fault_a = 1'b1;
        pulse_a();
        send_a(16'h0011, 1'b0, 0);
        send_a(16'h0022, 1'b0, 0);
        send_a(16'h0033, 1'b0, 0);
        wait_idle_a("t2_settle");
        check("t2_err", {30'd0, err_a}, {30'd0, ERR_VERIFY});
        check("t2_addr", {24'd0, ifa.addressbus}, 32'd2);
        check("t2_cu", {31'd0, cu_enable_a}, 32'd0);
        check("t2_word_count", {23'd0, wc_a}, 32'd2);
        check("t2_in_ready", {31'd0, ifa.in_ready}, 32'd0);
        fault_a = 1'b0;

        // Test 5: restart from ERROR, reset during WRITE of word 3
        pulse_a();
        check("t5_restart", {21'd0, err_a, wc_a}, 32'd0);
        check("t5_restart_addr", {24'd0, ifa.addressbus}, 32'd0);
        send_a(16'h0101, 1'b0, 0);
        send_a(16'h0202, 1'b0, 0);
        send_a(16'h0303, 1'b0, 0);
        check("t5_in_write", {31'd0, ifa.write}, 32'd1);
        load_start_a = 1'b1;
        @(negedge clk);
        load_start_a = 1'b0;
        check("t5_ignore_start_write", {31'd0, ifa.write}, 32'd1);
        check("t5_ignore_start_count", {23'd0, wc_a}, 32'd2);
        check("t5_ignore_start_addr", {24'd0, ifa.addressbus}, 32'd2);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_write", {31'd0, ifa.write}, 32'd0);
        check("t5_rst_count", {23'd0, wc_a}, 32'd0);
        check("t5_rst_idle", {29'd0, busy_a, ifa.in_ready, ifa.read}, 32'd0);
        check("t5_rst_addr", {24'd0, ifa.addressbus}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Test 4: base FE, four words wrap through 00, stop in DONE
        pulse_b();
        send_b(16'h00B0, 1'b0);
        send_b(16'h00B1, 1'b0);
        send_b(16'h00B2, 1'b0);
        send_b(16'h00B3, 1'b1);
        wait_idle_b("t4_settle");
        check("t4_ram_fe", {16'd0, mem_b[8'hFE]}, 32'h00B0);
        check("t4_ram_ff", {16'd0, mem_b[8'hFF]}, 32'h00B1);
        check("t4_ram_00", {16'd0, mem_b[8'h00]}, 32'h00B2);
        check("t4_ram_01", {16'd0, mem_b[8'h01]}, 32'h00B3);
        check("t4_cu", {31'd0, cu_enable_b}, 32'd0);
        check("t4_word_count", {23'd0, wc_b}, 32'd4);
        check("t4_err", {30'd0, err_b}, 32'd0);
        check("t4_addr", {24'd0, ifb.addressbus}, 32'h01);

        // Test 3: MAX_WORDS=4 with no in_last -> overflow
        pulse_b();
        send_b(16'h00C0, 1'b0);
        send_b(16'h00C1, 1'b0);
        send_b(16'h00C2, 1'b0);
        send_b(16'h00C3, 1'b0);
        ifb.in_valid = 1'b1;
        ifb.in_data  = 16'h00C4;
        ifb.in_last  = 1'b0;
        ready_seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ifb.in_ready) ready_seen++;
        end
        ifb.in_valid = 1'b0;
        check("t3_ready_never", ready_seen, 32'd0);
        check("t3_err", {30'd0, err_b}, {30'd0, ERR_OVERFLOW});
        check("t3_word_count", {23'd0, wc_b}, 32'd4);
        check("t3_busy", {31'd0, busy_b}, 32'd0);
        check("t3_addr", {24'd0, ifb.addressbus}, 32'h01);

        check("strobes_exclusive", both_hi, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
